// File: rtl/ovf_pkg.sv
// Shared full-scale code and counter saturation helpers for the overflow monitor.
// Latency: n/a (constants and pure functions evaluated at elaboration).
// Backpressure: n/a.
package ovf_pkg;

    // Widest sample or counter the helpers support.
    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] wide_t;

    // Most-positive two's-complement code of a w-bit sample: 0 followed by ones.
    function automatic wide_t fs_pos(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w + 1);
    endfunction

    // Most-negative two's-complement code of a w-bit sample: 1 followed by zeros.
    function automatic wide_t fs_neg(input int w);
        return wide_t'(1) << (w - 1);
    endfunction

    // Largest value a w-bit unsigned counter can hold.
    function automatic wide_t sat_max(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

endpackage

// File: rtl/ovf_chan.sv
// One channel: full-scale detection, sticky clip flag, saturating window count.
// Latency: clip and clip_cnt update on the edge that samples the valid input.
// Backpressure: none; a sample is consumed whenever valid is high.
//
// Ports: clk/rst_n (already synchronised), sample/valid from the shared input,
// clear and win_end from the top-level window logic, clip (sticky flag),
// clip_nxt (next-state of clip, for the registered OR in the top) and
// clip_cnt (count of the last completed window).
module ovf_chan
    import ovf_pkg::*;
#(
    parameter int DIN_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] sample,
    input  logic                 valid,
    input  logic                 clear,
    input  logic                 win_end,
    output logic                 clip,
    output logic                 clip_nxt,
    output logic [CNT_WIDTH-1:0] clip_cnt
);

    localparam wide_t                POS_W   = fs_pos(DIN_WIDTH);
    localparam wide_t                NEG_W   = fs_neg(DIN_WIDTH);
    localparam wide_t                SAT_W   = sat_max(CNT_WIDTH);
    localparam logic [DIN_WIDTH-1:0] FS_POS  = POS_W[DIN_WIDTH-1:0];
    localparam logic [DIN_WIDTH-1:0] FS_NEG  = NEG_W[DIN_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = SAT_W[CNT_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 clip_q,     clip_d;
    logic [CNT_WIDTH-1:0] run_q,      run_d;
    logic [CNT_WIDTH-1:0] clip_cnt_q, clip_cnt_d;
    logic                 hit;
    logic [CNT_WIDTH-1:0] run_inc;

    always_comb begin
        hit = valid && ((sample == FS_POS) || (sample == FS_NEG));

        // Running count including the current sample, pinned at full scale.
        run_inc = run_q;
        if (hit && (run_q != CNT_SAT)) begin
            run_inc = run_q + CNT_ONE;
        end

        clip_d     = clip_q | hit;
        run_d      = run_q;
        clip_cnt_d = clip_cnt_q;

        // Clear overrides both the new hit and any window end in this cycle.
        if (clear) begin
            clip_d = 1'b0;
            run_d  = '0;
        end else if (win_end) begin
            clip_cnt_d = run_inc;
            run_d      = '0;
        end else begin
            run_d = run_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q     <= 1'b0;
            run_q      <= '0;
            clip_cnt_q <= '0;
        end else begin
            clip_q     <= clip_d;
            run_q      <= run_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip     = clip_q;
    assign clip_nxt = clip_d;
    assign clip_cnt = clip_cnt_q;

endmodule

// File: rtl/multi_ovf_monitor.sv
// Multi-channel full-scale (clip) monitor with sticky flags and windowed counts.
// Latency: 1 cycle from a valid sample to clip/clip_any/clip_cnt/cnt_valid.
// Backpressure: none; every din_valid cycle is consumed.
//
// Ports: clk, rst (async assert, active-low, released synchronously),
// din/din_valid (N_CHANNELS packed samples), clear (sync clear), win_len
// (samples per window, 0 acts as 1), clip/clip_any (sticky flags),
// clip_cnt/cnt_valid (per-window counts and their update strobe).
module multi_ovf_monitor
    import ovf_pkg::*;
#(
    parameter int DIN_WIDTH  = 8,
    parameter int N_CHANNELS = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int WIN_WIDTH  = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_CHANNELS*DIN_WIDTH-1:0] din,
    input  logic                            din_valid,
    input  logic                            clear,
    input  logic [WIN_WIDTH-1:0]            win_len,
    output logic [N_CHANNELS-1:0]           clip,
    output logic                            clip_any,
    output logic [N_CHANNELS*CNT_WIDTH-1:0] clip_cnt,
    output logic                            cnt_valid
);

    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    // Reset asserts asynchronously and releases two edges later.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic [WIN_WIDTH-1:0]  win_cnt_q,   win_cnt_d;
    logic [WIN_WIDTH-1:0]  win_len_q,   win_len_d;
    logic                  cnt_valid_q, cnt_valid_d;
    logic                  clip_any_q,  clip_any_d;
    logic [WIN_WIDTH-1:0]  win_len_in;
    logic [WIN_WIDTH-1:0]  win_len_cur;
    logic                  win_end;
    logic [N_CHANNELS-1:0] clip_nxt;

    always_comb begin
        win_len_in = (win_len == '0) ? WIN_ONE : win_len;

        // The first sample of a window uses the live input, since that is
        // the sample at which the length is captured.
        win_len_cur = (win_cnt_q == '0) ? win_len_in : win_len_q;
        win_end     = din_valid && !clear && (win_cnt_q == (win_len_cur - WIN_ONE));

        win_cnt_d = win_cnt_q;
        win_len_d = win_len_q;
        if (clear) begin
            win_cnt_d = '0;
        end else if (din_valid) begin
            if (win_cnt_q == '0) begin
                win_len_d = win_len_in;
            end
            win_cnt_d = win_end ? '0 : (win_cnt_q + WIN_ONE);
        end

        cnt_valid_d = win_end;
        clip_any_d  = |clip_nxt;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            win_cnt_q   <= '0;
            win_len_q   <= WIN_ONE;
            cnt_valid_q <= 1'b0;
            clip_any_q  <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            win_len_q   <= win_len_d;
            cnt_valid_q <= cnt_valid_d;
            clip_any_q  <= clip_any_d;
        end
    end

    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_chan
        ovf_chan #(
            .DIN_WIDTH (DIN_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n_int),
            .sample   (din[k*DIN_WIDTH +: DIN_WIDTH]),
            .valid    (din_valid),
            .clear    (clear),
            .win_end  (win_end),
            .clip     (clip[k]),
            .clip_nxt (clip_nxt[k]),
            .clip_cnt (clip_cnt[k*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign clip_any  = clip_any_q;
    assign cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_multi_ovf_monitor.sv
module tb_multi_ovf_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance, default parameters.
    logic [31:0] din       = '0;
    logic        din_valid = 1'b0;
    logic        clear     = 1'b0;
    logic [23:0] win_len   = 24'd4;
    logic [3:0]  clip;
    logic        clip_any;
    logic [63:0] clip_cnt;
    logic        cnt_valid;

    // Narrow-counter instance for saturation.
    logic [31:0] din2       = '0;
    logic        din_valid2 = 1'b0;
    logic        clear2     = 1'b0;
    logic [23:0] win_len2   = 24'd20;
    logic [3:0]  clip2;
    logic        clip_any2;
    logic [15:0] clip_cnt2;
    logic        cnt_valid2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_ovf_monitor u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .win_len   (win_len),
        .clip      (clip),
        .clip_any  (clip_any),
        .clip_cnt  (clip_cnt),
        .cnt_valid (cnt_valid)
    );

    multi_ovf_monitor #(.CNT_WIDTH(4)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .din       (din2),
        .din_valid (din_valid2),
        .clear     (clear2),
        .win_len   (win_len2),
        .clip      (clip2),
        .clip_any  (clip_any2),
        .clip_cnt  (clip_cnt2),
        .cnt_valid (cnt_valid2)
    );

    typedef struct {
        logic        vld;
        logic        clr;
        logic [23:0] wl;
        logic [31:0] din;
        logic [3:0]  e_clip;
        logic        e_any;
        logic        e_cv;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic vld, input logic clr, input logic [23:0] wl,
                       input logic [31:0] d, input logic [3:0] e_clip,
                       input logic e_any, input logic e_cv, input logic [63:0] e_cnt);
        vec_t v;
        v.vld = vld; v.clr = clr; v.wl = wl; v.din = d;
        v.e_clip = e_clip; v.e_any = e_any; v.e_cv = e_cv; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic vld, input logic clr, input logic [23:0] wl,
                        input logic [31:0] d);
        @(negedge clk);
        din_valid = vld;
        clear     = clr;
        win_len   = wl;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] e_clip, input logic e_any,
                              input logic e_cv, input logic [63:0] e_cnt);
        chk({tag, ".clip"},      64'(clip),      64'(e_clip));
        chk({tag, ".clip_any"},  64'(clip_any),  64'(e_any));
        chk({tag, ".cnt_valid"}, 64'(cnt_valid), 64'(e_cv));
        chk({tag, ".clip_cnt"},  clip_cnt,       e_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   vld clr wl  din            clip    any cv cnt
        add(1, 0, 4, 32'h0000_0080, 4'b0001, 1, 0, 64'h0);
        add(1, 0, 4, 32'h0000_0000, 4'b0001, 1, 0, 64'h0);
        add(0, 0, 4, 32'h7F7F_7F7F, 4'b0001, 1, 0, 64'h0);
        add(1, 1, 4, 32'h0000_0000, 4'b0000, 0, 0, 64'h0);
        add(1, 0, 4, 32'h007F_0000, 4'b0100, 1, 0, 64'h0);
        add(1, 0, 4, 32'h007F_0000, 4'b0100, 1, 0, 64'h0);
        add(1, 0, 4, 32'h0010_0000, 4'b0100, 1, 0, 64'h0);
        add(1, 0, 4, 32'h007F_0000, 4'b0100, 1, 1, 64'h0000_0003_0000_0000);
        add(0, 0, 2, 32'h0000_0000, 4'b0100, 1, 0, 64'h0000_0003_0000_0000);
        add(0, 0, 2, 32'h8080_8080, 4'b0100, 1, 0, 64'h0000_0003_0000_0000);
        add(1, 0, 2, 32'h0000_0081, 4'b0100, 1, 0, 64'h0000_0003_0000_0000);
        add(1, 0, 2, 32'h0000_0000, 4'b0100, 1, 1, 64'h0);
        add(1, 0, 0, 32'h8000_0000, 4'b1100, 1, 1, 64'h0001_0000_0000_0000);
        add(1, 0, 0, 32'h0000_0000, 4'b1100, 1, 1, 64'h0);
        add(1, 0, 3, 32'h0000_007F, 4'b1101, 1, 0, 64'h0);
        add(1, 0, 1, 32'h0000_007F, 4'b1101, 1, 0, 64'h0);
        add(1, 0, 1, 32'h0000_0000, 4'b1101, 1, 1, 64'h0000_0000_0000_0002);
        add(1, 0, 2, 32'h0000_8000, 4'b1111, 1, 0, 64'h0000_0000_0000_0002);
        add(1, 1, 2, 32'h0000_8000, 4'b0000, 0, 0, 64'h0000_0000_0000_0002);
        add(1, 0, 2, 32'h0000_0000, 4'b0000, 0, 0, 64'h0000_0000_0000_0002);
        add(1, 0, 2, 32'h0000_8000, 4'b0010, 1, 1, 64'h0000_0000_0001_0000);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_main("reset", 4'b0000, 1'b0, 1'b0, 64'h0);
        chk("reset.sat_clip_cnt", 64'(clip_cnt2), 64'h0);

        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].vld, vq[i].clr, vq[i].wl, vq[i].din);
            check_main($sformatf("vec%0d", i), vq[i].e_clip, vq[i].e_any,
                       vq[i].e_cv, vq[i].e_cnt);
        end

        // Reset mid-window: two of three samples in, then async reset.
        step(1, 0, 3, 32'h0000_0080);
        step(1, 0, 3, 32'h0000_0080);
        @(negedge clk);
        din_valid = 1'b0;
        din       = '0;
        #2;
        rst = 1'b0;
        #1;
        check_main("async_rst", 4'b0000, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        step(1, 0, 3, 32'h0000_0080);
        check_main("post_rst1", 4'b0001, 1'b1, 1'b0, 64'h0);
        step(1, 0, 3, 32'h0000_0080);
        check_main("post_rst2", 4'b0001, 1'b1, 1'b0, 64'h0);
        step(1, 0, 3, 32'h0000_0080);
        check_main("post_rst3", 4'b0001, 1'b1, 1'b1, 64'h0000_0000_0000_0003);
        step(0, 0, 3, 32'h0000_0000);

        // Saturation on the 4-bit counter instance: 20 full-scale samples.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            din_valid2 = 1'b1;
            win_len2   = 24'd20;
            din2       = 32'h8080_8080;
            @(posedge clk);
            #1;
            if (i == 18) begin
                chk("sat.cnt_valid_early", 64'(cnt_valid2), 64'h0);
            end
        end
        chk("sat.cnt_valid", 64'(cnt_valid2), 64'h1);
        chk("sat.clip_cnt",  64'(clip_cnt2),  64'hFFFF);
        chk("sat.clip",      64'(clip2),      64'hF);
        chk("sat.clip_any",  64'(clip_any2),  64'h1);
        @(negedge clk);
        din_valid2 = 1'b0;
        @(posedge clk);
        #1;
        chk("sat.cnt_valid_drop", 64'(cnt_valid2), 64'h0);
        chk("sat.clip_cnt_hold",  64'(clip_cnt2),  64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_ovf_monitor.md
MULTI_OVF_MONITOR -- requirements
Module: multi_ovf_monitor

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 8: bits per signed two's-complement sample.
REQ-002 SHALL have parameter N_CHANNELS, default 4: number of monitored channels.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of each per-window clip counter.
REQ-004 SHALL have parameter WIN_WIDTH, default 24: width of the window-length input and sample counter.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port din, input, N_CHANNELS*DIN_WIDTH: channel k occupies bits [k*DIN_WIDTH +: DIN_WIDTH].
REQ-008 SHALL have port din_valid, input, 1: all channels in din are valid this cycle.
REQ-009 SHALL have port clear, input, 1: synchronous clear of sticky flags, running counts and window position.
REQ-010 SHALL have port win_len, input, WIN_WIDTH: valid samples per measurement window.
REQ-011 SHALL have port clip, output, N_CHANNELS: per-channel sticky clip flag.
REQ-012 SHALL have port clip_any, output, 1: OR of all bits of clip.
REQ-013 SHALL have port clip_cnt, output, N_CHANNELS*CNT_WIDTH: per-channel clip count of the last completed window.
REQ-014 SHALL have port cnt_valid, output, 1: one-cycle pulse when clip_cnt updates.

Function
REQ-015 A sample SHALL be clipped when it equals the most-negative code (1 followed by zeros) or the most-positive code (0 followed by ones).
REQ-016 Clip detection SHALL only act on cycles with din_valid=1; samples with din_valid=0 SHALL be ignored.
REQ-017 clip[k] SHALL rise on the clock edge that samples a valid clipped sample on channel k (1-cycle latency) and SHALL stay high until clear or reset.
REQ-018 clip_any SHALL be registered and SHALL rise on the same edge as the first rising clip bit.
REQ-019 Each channel SHALL keep a running count of valid clipped samples in the current window, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-020 A window sample counter SHALL increment on each valid cycle; the valid sample at which the counter reaches win_len-1 SHALL end the window.
REQ-021 At window end, clip_cnt SHALL load each running count including that final sample, cnt_valid SHALL pulse on the same edge, and running counts and the window counter SHALL return to 0.
REQ-022 win_len SHALL be sampled at window start and held internally; changes mid-window SHALL take effect from the next window.
REQ-023 win_len=0 SHALL be treated as 1, closing a window on every valid sample.
REQ-024 When clear=1, sticky flags, clip_any, running counts and the window counter SHALL be zeroed and cnt_valid SHALL be 0.
REQ-025 clip_cnt SHALL hold its last value on clear.
REQ-026 When clear coincides with a clipped sample or a window end, clear SHALL win: no flag is set, no count is taken and no cnt_valid pulse is issued.
REQ-027 The first window after clear or reset SHALL start with the next valid sample.

Reset
REQ-028 Reset active (rst=0) SHALL asynchronously force clip, clip_any, clip_cnt, cnt_valid, running counts and the window counter to 0.
REQ-029 The stored window length SHALL reset to 1.
REQ-030 Deassertion of reset SHALL be synchronised internally, so outputs leave reset on a clock edge.

Structure
REQ-031 The full-scale code computation and the counter-saturation constant SHALL reside in shared package ovf_pkg.
REQ-032 Per-channel detection, sticky flag and saturating counter SHALL be sub-module ovf_chan, instantiated N_CHANNELS times by a generate loop.
REQ-033 The window counter and cnt_valid logic SHALL be in the top level, shared by all channels.

Verification
REQ-034 Reset, then ch0 = 0x80 with valid=1 -> clip=4'b0001 and clip_any=1 one cycle later; clip held after din returns to 0x00.
REQ-035 Set win_len=4 and drive 4 valid samples with ch2 = 0x7F,0x7F,0x10,0x7F -> cnt_valid pulse on the 4th sample, ch2 clip_cnt=3, other channels 0.
REQ-036 Clipped sample with valid=0 -> no flag and no count change.
REQ-037 Assert clear on the same cycle as a window-end clipped sample -> no cnt_valid pulse, clip=0, clip_cnt keeps its prior value.
REQ-038 CNT_WIDTH=4, win_len=20, all samples 0x80 -> clip_cnt=15 on every channel (saturation, no wrap).
REQ-039 Assert rst=0 mid-window between clock edges -> outputs drop to 0 immediately; after release, the next window counts from sample 1.
